// File: rtl/kyber_encode_pkg.sv
// Shared types and helpers for the streamed ByteEncode_d controller.
// ENCODE_RANGE_CHECK_EN uses coef_in_range() to flag out-of-range coefficients.
package kyber_encode_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  typedef logic signed [15:0] coef_t;

  function automatic logic is_legal_d(input logic [3:0] d);
    logic legal;
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // d=12 carries mod-q values, so the bound is q rather than 2^12
  function automatic logic coef_in_range(input logic [15:0] c, input logic [3:0] d);
    logic ok;
    if (d == 4'd12) begin
      ok = (c < 16'(KYBER_Q));
    end else begin
      ok = ((c >> d) == 16'd0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/encode_stream_ctrl_bit_packer.sv
// Bit accumulator for ByteEncode_d: packs d-bit fields LSB-first and releases
// them a byte at a time. Push and pop never coincide, so one update path suffices.
module bit_packer
  import kyber_encode_pkg::*;
#(
  parameter int MAX_D = 12,
  parameter int ACC_W = MAX_D + 8,
  parameter int CNT_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       d,
  input  logic [15:0]      coef,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [7:0]       byte_out
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [ACC_W-1:0] mask_s;
  logic [ACC_W-1:0] field_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next accumulator contents for clear, push or pop
  always_comb begin
    mask_s    = ~({ACC_W{1'b1}} << d);
    field_s   = ACC_W'(coef) & mask_s;
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    if (clr) begin
      acc_nxt_s = {ACC_W{1'b0}};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (push) begin
      acc_nxt_s = acc_r | (field_s << cnt_r);
      cnt_nxt_s = cnt_r + CNT_W'(d);
    end else if (pop) begin
      acc_nxt_s = acc_r >> 4'd8;
      cnt_nxt_s = cnt_r - CNT_W'(4'd8);
    end else begin
      acc_nxt_s = acc_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Accumulator and fill-level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign acc_cnt  = cnt_r;
  assign byte_out = acc_r[7:0];

endmodule

// File: rtl/encode_stream_ctrl.sv
// Streamed ByteEncode_d controller: one coefficient in, one byte out per handshake.
// Optional build macro ENCODE_RANGE_CHECK_EN adds the sticky err_range output.
module encode_stream_ctrl
  import kyber_encode_pkg::*;
#(
  parameter int MAX_D  = 12,
  parameter int N_COEF = KYBER_N
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  d_sel,
  output logic        busy,
  output logic        done,
  output logic        err_d,
`ifdef ENCODE_RANGE_CHECK_EN
  output logic        err_range,
`endif
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic [15:0] coef,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic [8:0]  byte_idx
);

  localparam int ACC_W = MAX_D + 8;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int CC_W  = $clog2(N_COEF + 1);
  localparam logic [CC_W-1:0] N_LAST = CC_W'(N_COEF);

  enc_state_e       state_r;
  enc_state_e       state_nxt_s;
  logic [3:0]       d_r;
  logic [CC_W-1:0]  coef_cnt_r;
  logic [8:0]       byte_idx_r;
  logic             busy_r;
  logic             done_r;
  logic             err_d_r;
  logic [CNT_W-1:0] acc_cnt_s;
  logic             legal_start_s;
  logic             bad_start_s;
  logic             push_s;
  logic             pop_s;
  logic             coef_ready_s;
  logic             byte_valid_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  assign legal_start_s = (state_r == IDLE) && start && is_legal_d(d_sel);
  assign bad_start_s   = (state_r == IDLE) && start && !is_legal_d(d_sel);
  assign push_s        = coef_valid && coef_ready_s;
  assign pop_s         = byte_valid_s && byte_ready;

  bit_packer #(
    .MAX_D (MAX_D)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (legal_start_s),
    .push     (push_s),
    .pop      (pop_s),
    .d        (d_r),
    .coef     (coef),
    .acc_cnt  (acc_cnt_s),
    .byte_out (byte_out)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a job ends once every coefficient is in and the accumulator is drained
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (legal_start_s) state_nxt_s = RUN;
        else               state_nxt_s = IDLE;
      end
      RUN: begin
        if ((coef_cnt_r == N_LAST) && (acc_cnt_s == {CNT_W{1'b0}})) state_nxt_s = DONE;
        else                                                        state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: handshake qualifiers and next values of busy/done
  always_comb begin
    coef_ready_s = 1'b0;
    byte_valid_s = 1'b0;
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        busy_nxt_s = legal_start_s;
        done_nxt_s = bad_start_s;
      end
      RUN: begin
        coef_ready_s = (coef_cnt_r < N_LAST) && (acc_cnt_s < CNT_W'(4'd8));
        byte_valid_s = (acc_cnt_s >= CNT_W'(4'd8));
        busy_nxt_s   = (state_nxt_s == RUN);
        done_nxt_s   = (state_nxt_s == DONE);
      end
      DONE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Job parameters, counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r        <= 4'd0;
      coef_cnt_r <= {CC_W{1'b0}};
      byte_idx_r <= 9'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_d_r    <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (legal_start_s) begin
        d_r        <= d_sel;
        coef_cnt_r <= {CC_W{1'b0}};
        byte_idx_r <= 9'd0;
        err_d_r    <= 1'b0;
      end else begin
        if (bad_start_s) err_d_r    <= 1'b1;
        if (push_s)      coef_cnt_r <= coef_cnt_r + CC_W'(1'b1);
        if (pop_s)       byte_idx_r <= byte_idx_r + 9'd1;
      end
    end
  end

`ifdef ENCODE_RANGE_CHECK_EN
  logic err_range_r;

  // Sticky per-job flag for accepted coefficients wider than d bits (or >= q at d=12)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range_r <= 1'b0;
    end else if (legal_start_s) begin
      err_range_r <= 1'b0;
    end else if (push_s && !coef_in_range(coef, d_r)) begin
      err_range_r <= 1'b1;
    end else begin
      err_range_r <= err_range_r;
    end
  end

  assign err_range = err_range_r;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign err_d      = err_d_r;
  assign coef_ready = coef_ready_s;
  assign byte_valid = byte_valid_s;
  assign byte_idx   = byte_idx_r;

endmodule
